// File: rtl/rst_domain_sequencer.sv
// Reset-domain sequencer: waits for PLL lock and DDR calibration, releases
// the domain resets one at a time with a fixed hold between stages, and
// serves masked software reset requests once the system is running. Loss of
// PLL lock at any point drops the system back to full reset.
module rst_domain_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                   wb_clk,
  input  logic                   release_cpu_reset,
  input  logic                   pll_locked,
  input  logic                   ddr_cal_done,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] sw_rst_mask,
  output logic                   sw_rst_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   seq_busy,
  output logic [2:0]             seq_state,
  output logic                   lock_fault
);

  // Index needs one code past the last domain so SW_RELEASE can tell
  // "all domains walked" apart from "working on the last domain".
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NUM_DOMAINS);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_WAIT_CAL   = 3'd1,
    ST_RELEASE    = 3'd2,
    ST_RUN        = 3'd3,
    ST_SW_ASSERT  = 3'd4,
    ST_SW_RELEASE = 3'd5,
    ST_SW_ACK     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] mask_q, mask_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                   ack_q, ack_d;
  logic                   fault_q, fault_d;

  logic lock_meta_q, lock_sync_q;
  logic cal_meta_q, cal_sync_q;

  logic [NUM_DOMAINS-1:0] cur_sel;
  logic                   hold_done;
  logic                   cur_masked;

  // Two-flop synchronizers for the asynchronous PLL lock and DDR cal status.
  // NOTE: synchronizer flops are reset to 0 so a stale "locked" can never
  // leak through the first two cycles after reset release.
  always_ff @(posedge wb_clk or negedge release_cpu_reset) begin
    if (!release_cpu_reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      cal_meta_q  <= 1'b0;
      cal_sync_q  <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
      cal_meta_q  <= ddr_cal_done;
      cal_sync_q  <= cal_meta_q;
    end
  end

  // Next-state, counter, index and output computation for the sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    dom_rst_d = dom_rst_q;
    ack_d     = 1'b0;
    fault_d   = fault_q;

    for (int i = 0; i < NUM_DOMAINS; i++) begin
      cur_sel[i] = (IDX_W'(i) == idx_q);
    end
    hold_done  = (cnt_q == HOLD_LAST);
    cur_masked = |(cur_sel & mask_q);

    case (state_q)
      ST_WAIT_LOCK: begin
        dom_rst_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
        if (lock_sync_q) state_d = ST_WAIT_CAL;
      end

      ST_WAIT_CAL: begin
        dom_rst_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
        if (cal_sync_q) state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (hold_done) begin
          cnt_d     = '0;
          dom_rst_d = dom_rst_q & ~cur_sel;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        dom_rst_d = '0;
        cnt_d     = '0;
        idx_d     = '0;
        if (sw_rst_req) begin
          mask_d    = sw_rst_mask;
          dom_rst_d = sw_rst_mask;
          state_d   = ST_SW_ASSERT;
        end
      end

      ST_SW_ASSERT: begin
        if (hold_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_SW_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SW_RELEASE: begin
        if (idx_q == IDX_DONE) begin
          state_d = ST_SW_ACK;
          ack_d   = 1'b1;
        end else if (cur_masked) begin
          if (hold_done) begin
            cnt_d     = '0;
            dom_rst_d = dom_rst_q & ~cur_sel;
            idx_d     = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Unmasked domains are skipped in a single cycle.
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_SW_ACK: begin
        ack_d = 1'b1;
        if (!sw_rst_req) begin
          state_d = ST_RUN;
          ack_d   = 1'b0;
        end
      end

      default: begin
        state_d   = ST_WAIT_LOCK;
        dom_rst_d = '1;
        cnt_d     = '0;
        idx_d     = '0;
      end
    endcase

    // Lock loss overrides whatever the state logic decided above.
    if (state_q != ST_WAIT_LOCK && !lock_sync_q) begin
      state_d   = ST_WAIT_LOCK;
      dom_rst_d = '1;
      ack_d     = 1'b0;
      fault_d   = 1'b1;
      cnt_d     = '0;
      idx_d     = '0;
    end
  end

  // Sequencer state register; reset forces every domain into reset at once.
  always_ff @(posedge wb_clk or negedge release_cpu_reset) begin
    if (!release_cpu_reset) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      dom_rst_q <= '1;
      ack_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      dom_rst_q <= dom_rst_d;
      ack_q     <= ack_d;
      fault_q   <= fault_d;
    end
  end

  assign dom_rst    = dom_rst_q;
  assign sw_rst_ack = ack_q;
  assign lock_fault = fault_q;
  assign seq_state  = state_q;
  assign seq_busy   = (state_q != ST_RUN);

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Testbench for rst_domain_sequencer. Stimulus tasks predict the timeline of
// output changes (edge number and full output bundle) from the sequencing
// rules and queue them; a monitor compares each observed output change
// against the next queued prediction.
module tb_rst_domain_sequencer;

  localparam int N = 4;
  localparam int H = 4;

  logic         wb_clk = 1'b0;
  logic         release_cpu_reset;
  logic         pll_locked;
  logic         ddr_cal_done;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic         sw_rst_ack;
  logic [N-1:0] dom_rst;
  logic         seq_busy;
  logic [2:0]   seq_state;
  logic         lock_fault;

  rst_domain_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(H),
    .CNT_W      (8)
  ) dut (
    .wb_clk           (wb_clk),
    .release_cpu_reset(release_cpu_reset),
    .pll_locked       (pll_locked),
    .ddr_cal_done     (ddr_cal_done),
    .sw_rst_req       (sw_rst_req),
    .sw_rst_mask      (sw_rst_mask),
    .sw_rst_ack       (sw_rst_ack),
    .dom_rst          (dom_rst),
    .seq_busy         (seq_busy),
    .seq_state        (seq_state),
    .lock_fault       (lock_fault)
  );

  always #5 wb_clk = ~wb_clk;

  // Edge counter: after the k-th rising edge, cyc == k.
  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected output timeline.
  typedef struct {
    int         cyc;
    logic [9:0] b;
    string      tag;
  } ev_t;

  ev_t        exp_q[$];
  logic [N-1:0] m_dom;
  logic [2:0] m_st;
  logic       m_ack;
  logic       m_fault;
  logic [9:0] last_exp;

  // Bundle layout: {dom_rst, seq_state, sw_rst_ack, lock_fault, seq_busy}.
  function automatic logic [9:0] pack(input logic [N-1:0] d, input logic [2:0] s,
                                      input logic a, input logic f);
    return {d, s, a, f, (s != 3'd3)};
  endfunction

  task automatic expect_at(input int c, input string tag);
    logic [9:0] b;
    ev_t        e;
    b = pack(m_dom, m_st, m_ack, m_fault);
    if (b != last_exp) begin
      e.cyc = c;
      e.b   = b;
      e.tag = tag;
      exp_q.push_back(e);
      last_exp = b;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge wb_clk);
      #1;
    end
  endtask

  // Power-up release timeline: cal_done driven just after edge t, so the
  // sequencer enters RELEASE at t+3 and domain i leaves reset H*(i+1) later.
  task automatic push_release(input int t, input int upto);
    m_st = 3'd2;
    expect_at(t + 3, "release_entry");
    for (int i = 0; i < upto; i++) begin
      m_dom[i] = 1'b0;
      if (i == N - 1) m_st = 3'd3;
      expect_at(t + 3 + H * (i + 1), $sformatf("dom%0d_release", i));
    end
  endtask

  // Drive lock then cal_done and predict the timeline; returns cal drive edge.
  task automatic bring_up(input int upto, output int t);
    int m;
    m = cyc;
    pll_locked = 1'b1;
    m_st = 3'd1;
    expect_at(m + 3, "wait_cal_entry");
    wait_cyc(m + 5);
    t = cyc;
    ddr_cal_done = 1'b1;
    push_release(t, upto);
    if (upto == N) wait_cyc(t + 3 + H * N + 2);
  endtask

  // Software reset timeline for a request first sampled at edge s.
  task automatic push_sw(input int s, input logic [N-1:0] mask, output int ack_edge);
    int t;
    m_st  = 3'd4;
    m_dom = mask;
    expect_at(s, "sw_assert");
    t    = s + H;
    m_st = 3'd5;
    expect_at(t, "sw_release");
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        t += H;
        m_dom[i] = 1'b0;
        expect_at(t, $sformatf("sw_dom%0d_release", i));
      end else begin
        t += 1;
      end
    end
    t += 1;
    m_st  = 3'd6;
    m_ack = 1'b1;
    expect_at(t, "sw_ack");
    ack_edge = t;
  endtask

  // Monitor: every change of the output bundle must match the next prediction.
  initial begin
    logic [9:0] prev;
    logic [9:0] cur;
    ev_t        e;
    prev = pack('1, 3'd0, 1'b0, 1'b0);
    forever begin
      @(negedge wb_clk);
      cur = {dom_rst, seq_state, sw_rst_ack, lock_fault, seq_busy};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got 0x%0h, expected no change (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_cycle"}, cyc, e.cyc);
          check({e.tag, "_outputs"}, 32'(cur), 32'(e.b));
        end
        prev = cur;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, l, s, ack_edge, d, run_edge, r;
    logic [N-1:0] mask;

    release_cpu_reset = 1'b1;
    pll_locked        = 1'b0;
    ddr_cal_done      = 1'b0;
    sw_rst_req        = 1'b0;
    sw_rst_mask       = '0;
    m_dom   = '1;
    m_st    = 3'd0;
    m_ack   = 1'b0;
    m_fault = 1'b0;
    last_exp = pack(m_dom, m_st, m_ack, m_fault);

    // Reset values.
    #1 release_cpu_reset = 1'b0;
    #1;
    check("reset_dom_rst", 32'(dom_rst), 32'hF);
    check("reset_state", 32'(seq_state), 0);
    check("reset_ack", 32'(sw_rst_ack), 0);
    check("reset_busy", 32'(seq_busy), 1);
    check("reset_fault", 32'(lock_fault), 0);

    wait_cyc(3);
    release_cpu_reset = 1'b1;
    wait_cyc(5);

    // Power-up, interrupted by lock loss right after domain 0 is released.
    bring_up(1, t);
    wait_cyc(t + 3 + H);
    l = cyc;
    pll_locked   = 1'b0;
    ddr_cal_done = 1'b0;
    m_dom   = '1;
    m_st    = 3'd0;
    m_fault = 1'b1;
    expect_at(l + 3, "lock_loss_in_release");
    wait_cyc(l + 6);

    // Relock replays the full release timeline; fault stays sticky.
    bring_up(N, t);
    check("fault_sticky_after_relock", 32'(lock_fault), 1);
    check("busy_low_in_run", 32'(seq_busy), 0);

    // DDR calibration dropping while running is ignored.
    ddr_cal_done = 1'b0;
    wait_cyc(cyc + 6);
    ddr_cal_done = 1'b1;
    wait_cyc(cyc + 4);

    // Software reset requests: fixed mask 1010, zero mask, then random masks.
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      mask = 4'b1010;
      else if (k == 1) mask = 4'b0000;
      else             mask = N'($urandom_range(0, 15));
      s = cyc + 1;
      sw_rst_req  = 1'b1;
      sw_rst_mask = mask;
      push_sw(s, mask, ack_edge);
      wait_cyc(s);
      sw_rst_mask = N'($urandom);
      if (k == 0) d = ack_edge + 3;
      else        d = int'($urandom_range(s, ack_edge + 4));
      wait_cyc(d);
      sw_rst_req = 1'b0;
      run_edge = (d + 1 > ack_edge + 1) ? d + 1 : ack_edge + 1;
      m_st  = 3'd3;
      m_ack = 1'b0;
      expect_at(run_edge, "sw_return_run");
      wait_cyc(run_edge + int'($urandom_range(1, 4)));
    end

    // Lock loss seen in the same cycle a request arrives: lock loss wins.
    l = cyc;
    pll_locked   = 1'b0;
    ddr_cal_done = 1'b0;
    m_dom = '1;
    m_st  = 3'd0;
    expect_at(l + 3, "lock_loss_beats_req");
    wait_cyc(l + 2);
    sw_rst_req  = 1'b1;
    sw_rst_mask = '1;
    wait_cyc(l + 6);
    check("lock_vs_req_ack", 32'(sw_rst_ack), 0);
    check("lock_vs_req_state", 32'(seq_state), 0);
    sw_rst_req = 1'b0;
    wait_cyc(cyc + 2);
    bring_up(N, t);

    // Reset pulse during SW_RELEASE.
    s = cyc + 1;
    sw_rst_req  = 1'b1;
    sw_rst_mask = 4'b0110;
    m_st  = 3'd4;
    m_dom = 4'b0110;
    expect_at(s, "sw_assert_pre_reset");
    m_st = 3'd5;
    expect_at(s + H, "sw_release_pre_reset");
    wait_cyc(s + H + 2);
    r = cyc;
    m_dom   = '1;
    m_st    = 3'd0;
    m_ack   = 1'b0;
    m_fault = 1'b0;
    expect_at(r, "async_reset");
    release_cpu_reset = 1'b0;
    pll_locked        = 1'b0;
    ddr_cal_done      = 1'b0;
    sw_rst_req        = 1'b0;
    #1;
    check("async_reset_dom_rst", 32'(dom_rst), 32'hF);
    check("async_reset_fault", 32'(lock_fault), 0);
    check("async_reset_state", 32'(seq_state), 0);
    check("async_reset_ack", 32'(sw_rst_ack), 0);
    wait_cyc(r + 3);
    release_cpu_reset = 1'b1;
    wait_cyc(cyc + 2);
    bring_up(N, t);
    check("fault_clear_after_reset", 32'(lock_fault), 0);

    wait_cyc(cyc + 5);
    check("all_events_observed", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
